// File: rtl/shift_deserializer_pkg.sv
// Shared types and encodings for the serial-to-parallel deserializer.
package shift_deserializer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b01;
   localparam logic [1:0] DIR_HOLD  = 2'b00;

   localparam int unsigned LANE_DEFAULT = 8;

endpackage

// File: rtl/shift_deserializer_lane.sv
// One byte lane of the deserializer datapath: bidirectional shift register
// with serial in and the bit being shifted out exposed to the neighbour lane.
module shift_lane
   import shift_deserializer_pkg::*;
#(
   parameter int unsigned LANE = LANE_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            left,
   input  logic            sin,
   output logic            sout_c,
   output logic [LANE-1:0] q
);

   // Bit leaving the lane on the next shift, fed to the adjacent lane.
   assign sout_c = left ? q[LANE-1] : q[0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else if (en) begin
         q <= left ? {q[LANE-2:0], sin} : {sin, q[LANE-1:1]};
      end
   end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer: accepts WIDTH bits MSB- or LSB-first into a
// chain of byte lanes and presents the assembled word with a valid/ready handoff.
module shift_deserializer
   import shift_deserializer_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned LANE  = LANE_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [1:0]                 dir,
   input  logic                       sin,
   input  logic                       sin_valid,
   output logic                       sin_ready,
   output logic [WIDTH-1:0]           dout,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   output logic [$clog2(WIDTH):0]     bit_count
);

   localparam int unsigned NL = WIDTH / LANE;
   localparam int unsigned CW = $clog2(WIDTH) + 1;

   state_t           state_q, state_d;
   logic             dir_left_q;
   logic             accept;
   logic             shift_left;
   logic [WIDTH-1:0] shreg;
   logic [NL-1:0]    lane_sout;

   // Next-state, handshake and lane control.
   always_comb begin
      state_d    = state_q;
      sin_ready  = 1'b0;
      accept     = 1'b0;
      shift_left = dir_left_q;

      if (state_q == IDLE) begin
         shift_left = dir[1];
      end

      case (state_q)
         IDLE:    sin_ready = (dir != DIR_HOLD);
         SHIFT:   sin_ready = 1'b1;
         default: sin_ready = 1'b0;
      endcase
      if (!rst_n) begin
         sin_ready = 1'b0;
      end
      accept = sin_ready && sin_valid;

      case (state_q)
         IDLE: begin
            if (accept) state_d = SHIFT;
         end
         SHIFT: begin
            if (accept && bit_count == CW'(WIDTH - 1)) state_d = FULL;
         end
         FULL: begin
            if (dout_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         dir_left_q <= 1'b1;
         bit_count  <= '0;
         dout_valid <= 1'b0;
      end else begin
         state_q    <= state_d;
         dout_valid <= (state_d == FULL);
         // Direction is frozen by the first bit of each word.
         if (accept && state_q == IDLE) begin
            dir_left_q <= dir[1];
         end
         if (state_q == FULL && dout_ready) begin
            bit_count <= '0;
         end else if (accept) begin
            bit_count <= bit_count + CW'(1);
         end
      end
   end

   // Lane 0 holds the LSBs; the end lanes take sin depending on direction.
   for (genvar i = 0; i < NL; i++) begin : g_lane
      logic from_lo;
      logic from_hi;

      if (i == 0) begin : g_lo_end
         assign from_lo = sin;
      end else begin : g_lo_chain
         assign from_lo = lane_sout[i-1];
      end

      if (i == NL - 1) begin : g_hi_end
         assign from_hi = sin;
      end else begin : g_hi_chain
         assign from_hi = lane_sout[i+1];
      end

      shift_lane #(.LANE(LANE)) u_lane (
         .clk    (clk),
         .rst_n  (rst_n),
         .en     (accept),
         .left   (shift_left),
         .sin    (shift_left ? from_lo : from_hi),
         .sout_c (lane_sout[i]),
         .q      (shreg[i*LANE +: LANE])
      );
   end

   assign dout = shreg;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed self-checking bench for shift_deserializer (WIDTH=64, LANE=8).
module tb_shift_deserializer;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned CW    = $clog2(WIDTH) + 1;

   logic             clk;
   logic             rst_n;
   logic [1:0]       dir;
   logic             sin;
   logic             sin_valid;
   logic             sin_ready;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic [CW-1:0]    bit_count;

   int tests;
   int fails;

   typedef struct {
      logic [1:0]  dir;
      logic [63:0] word;
      int          flip_at;
      logic        gap;
      int          stall;
      logic [63:0] expect_word;
   } vec_t;

   vec_t vecs [5];

   shift_deserializer #(.WIDTH(WIDTH), .LANE(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .dir        (dir),
      .sin        (sin),
      .sin_valid  (sin_valid),
      .sin_ready  (sin_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .bit_count  (bit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int k);
      int cycles;
      int idx;
      cycles = 0;
      dir    = v.dir;
      for (int i = 0; i < 64; i++) begin
         if (v.flip_at != 0 && i == v.flip_at) dir = 2'b01;
         if (v.gap) begin
            sin_valid = 1'b0;
            sin       = 1'b1;
            tick();
            cycles++;
            check($sformatf("v%0d_gap_count_b%0d", k, i), 64'(bit_count), 64'(i));
         end
         idx       = v.dir[1] ? 63 - i : i;
         sin       = v.word[idx];
         sin_valid = 1'b1;
         tick();
         cycles++;
         check($sformatf("v%0d_count_b%0d", k, i), 64'(bit_count), 64'(i + 1));
         check($sformatf("v%0d_valid_b%0d", k, i), 64'(dout_valid), 64'(i == 63));
      end
      check($sformatf("v%0d_cycles", k), 64'(cycles), v.gap ? 64'd128 : 64'd64);
      check($sformatf("v%0d_dout", k), dout, v.expect_word);
      check($sformatf("v%0d_full_count", k), 64'(bit_count), 64'd64);
      check($sformatf("v%0d_full_ready", k), 64'(sin_ready), 64'd0);

      // Hold FULL with a busy consumer while the producer keeps offering bits.
      sin_valid  = 1'b1;
      sin        = ~sin;
      dout_ready = 1'b0;
      for (int s = 0; s < v.stall; s++) begin
         tick();
         check($sformatf("v%0d_stall%0d_valid", k, s), 64'(dout_valid), 64'd1);
         check($sformatf("v%0d_stall%0d_dout", k, s), dout, v.expect_word);
         check($sformatf("v%0d_stall%0d_count", k, s), 64'(bit_count), 64'd64);
         check($sformatf("v%0d_stall%0d_ready", k, s), 64'(sin_ready), 64'd0);
      end

      // Handoff cycle with sin_valid still high: nothing may be accepted.
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      sin_valid  = 1'b0;
      check($sformatf("v%0d_handoff_valid", k), 64'(dout_valid), 64'd0);
      check($sformatf("v%0d_handoff_count", k), 64'(bit_count), 64'd0);
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      rst_n      = 1'b0;
      dir        = 2'b10;
      sin        = 1'b0;
      sin_valid  = 1'b1;
      dout_ready = 1'b0;

      vecs[0] = '{dir: 2'b10, word: 64'hFFFF0000FFFF0000, flip_at: 0, gap: 1'b0, stall: 0,
                  expect_word: 64'hFFFF0000FFFF0000};
      vecs[1] = '{dir: 2'b10, word: 64'h0123456789ABCDEF, flip_at: 0, gap: 1'b0, stall: 5,
                  expect_word: 64'h0123456789ABCDEF};
      vecs[2] = '{dir: 2'b01, word: 64'h0123456789ABCDEF, flip_at: 0, gap: 1'b0, stall: 1,
                  expect_word: 64'h0123456789ABCDEF};
      vecs[3] = '{dir: 2'b10, word: 64'hA5A55A5A0F0FF0F0, flip_at: 0, gap: 1'b1, stall: 0,
                  expect_word: 64'hA5A55A5A0F0FF0F0};
      vecs[4] = '{dir: 2'b10, word: 64'hDEADBEEFCAFEF00D, flip_at: 10, gap: 1'b0, stall: 2,
                  expect_word: 64'hDEADBEEFCAFEF00D};

      // Reset state; sin_ready must stay low while reset is asserted.
      tick();
      tick();
      check("rst_valid", 64'(dout_valid), 64'd0);
      check("rst_count", 64'(bit_count), 64'd0);
      check("rst_dout", dout, 64'd0);
      check("rst_ready", 64'(sin_ready), 64'd0);

      // dir=00 in IDLE: not ready, nothing accepted.
      rst_n = 1'b1;
      dir   = 2'b00;
      sin   = 1'b1;
      #1;
      check("hold_ready", 64'(sin_ready), 64'd0);
      tick();
      check("hold_count", 64'(bit_count), 64'd0);
      dir = 2'b10;
      #1;
      check("left_ready", 64'(sin_ready), 64'd1);

      // Partial word of ones, then reset: the next word must carry no stale bits.
      for (int i = 0; i < 20; i++) tick();
      check("partial_count", 64'(bit_count), 64'd20);
      rst_n = 1'b0;
      tick();
      check("midrst_count", 64'(bit_count), 64'd0);
      check("midrst_valid", 64'(dout_valid), 64'd0);
      check("midrst_dout", dout, 64'd0);
      check("midrst_ready", 64'(sin_ready), 64'd0);
      rst_n     = 1'b1;
      sin_valid = 1'b0;
      tick();
      check("postrst_valid", 64'(dout_valid), 64'd0);
      check("postrst_count", 64'(bit_count), 64'd0);

      for (int k = 0; k < 5; k++) begin
         run_vec(vecs[k], k);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
